uart_rx_mmio: RTL
=================

Name: uart_rx_mmio

Overview:
Memory-mapped UART receiver. It is the receive-direction counterpart of the CPU-write UART transmitter on the data bus. It deserialises 8N1 frames from an asynchronous serial line and buffers the received bytes in a small FIFO. The CPU reads received bytes and status through load instructions in the memory stage, selected by the LSU's UART decode alongside dmem.

Parameters:
CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); must be >= 4
FIFO_DEPTH, 4, receive FIFO entries; power of two, >= 2
BASE_ADDR, 32'h0000_0400, byte address of the RXDATA register; STATUS is at BASE_ADDR+4

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
rx_i  in  1  serial input; idles high; asynchronous to clk
cpu_address  in  32  byte address from the EM-stage ALU result
read_enable  in  1  load strobe, already qualified with the UART select; one pulse = one access
read_data  out  32  register read data; combinational from cpu_address and current state
rx_irq  out  1  high while the FIFO is non-empty

Behaviour:
- Reset (reset=0, async): FSM=IDLE, counters=0, FIFO empty (rd/wr pointers 0), sticky flags 0, synchroniser flops=1, read_data=0, rx_irq=0.
- rx_i passes through a 2-flop synchroniser (rx_s). Edge detection uses rx_s and one more delayed copy.
- FSM states and transitions:
  - IDLE: on a 1->0 transition of rx_s, clear bit counter, load baud counter, go to START. A low line with no falling edge does not arm the FSM.
  - START: wait CLKS_PER_BIT/2 cycles, then sample rx_s. If 0, go to DATA. If 1, treat as a glitch and go to IDLE with no flags set.
  - DATA: wait CLKS_PER_BIT cycles per bit, sample rx_s into the shift register LSB-first, 8 bits. After bit 7, go to STOP.
  - STOP: wait CLKS_PER_BIT, then sample.
    - If 1 and FIFO not full: push byte.
    - If 1 and FIFO full: drop byte, set overrun.
    - If 0: discard byte, set frame_err.
    - In all cases go to IDLE.
- Baud counter width is clog2(CLKS_PER_BIT). Sample points fall mid-bit; total frame time is 9.5 bit periods before returning to IDLE.
- FIFO:
  - Pointers are clog2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - Empty when pointers are fully equal. Full when the MSBs differ and the remaining bits are equal.
- Register map (cpu_address compared on all 32 bits):
  - BASE_ADDR RXDATA: read_data = {24'b0, fifo head}, or 0 if empty. read_enable pops one entry; a pop on empty is ignored.
  - BASE_ADDR+4 STATUS: read_data = {28'b0, frame_err, overrun, full, ~empty}. read_enable clears both sticky bits on the following edge.
  - Any other address: read_data = 0, no side effects.
- Simultaneous push and pop in one cycle:
  - Both take effect; count is unchanged.
  - When full, the pop frees a slot, so the push succeeds with no overrun.
  - When empty, the popped value is 0 and the pushed byte remains.
- Simultaneous sticky set (STOP event) and STATUS-read clear: set wins, so the flag reads 1 next time.
- rx_irq is registered-free: it equals ~empty.
- Reset asserted mid-frame aborts the frame, empties the FIFO, and clears the flags. After release, the FSM waits for a fresh falling edge.
- Writes are not decoded; this block ignores stores.

Test Plan:
- CLKS_PER_BIT=16. Send 0xA5 (8N1) -> after 9.5 bit times, STATUS=0x1 and rx_irq=1. Load RXDATA -> 0x000000A5, then STATUS=0x0 and rx_irq=0.
- Send 0x01, 0x02, 0x03, 0x04, 0x05 without reading (depth 4):
  - STATUS=0x7 after the 5th byte.
  - Four RXDATA loads return 01, 02, 03, 04 in order.
  - Next STATUS read returns 0x4, then 0x0.
- Frame with stop bit 0 and data 0x3C -> no push, STATUS=0x8. A second STATUS read returns 0x0.
- Low glitch on rx_i of 4 cycles (< CLKS_PER_BIT/2) -> FSM returns to IDLE, FIFO unchanged, STATUS=0x0.
- FIFO full, with the 5th frame's stop sample coinciding with an RXDATA pop:
  - Pop returns the oldest byte.
  - New byte is stored.
  - Overrun stays 0.
  - FIFO count stays 4.
- Assert reset for 3 cycles during DATA bit 4 of a frame:
  - All outputs 0 and FIFO empty.
  - Remaining bits of the aborted frame do not produce a byte.
  - The next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_mmio_if.sv
// CPU load-side bus of the memory-mapped UART receiver.
// master = LSU/CPU side, slave = receiver.
interface uart_rx_mmio_if;
  logic [31:0] cpu_address;
  logic        read_enable;
  logic [31:0] read_data;
  logic        rx_irq;

  modport master (output cpu_address, read_enable, input read_data, rx_irq);
  modport slave  (input cpu_address, read_enable, output read_data, rx_irq);
endinterface

// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver: synchroniser, bit-timing FSM, byte FIFO, RXDATA/STATUS registers.
// state   | meaning
// S_IDLE  | line idle, waiting for a falling edge on the synchronised line
// S_START | half-bit wait, then confirm the start bit is still low
// S_DATA  | eight mid-bit samples, LSB first
// S_STOP  | one bit wait, then push / flag overrun / flag framing error
module uart_rx_mmio #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_i,
  uart_rx_mmio_if.slave bus
);
  localparam int unsigned   CW          = $clog2(CLKS_PER_BIT);
  localparam int unsigned   AW          = $clog2(FIFO_DEPTH);
  localparam int unsigned   PW          = AW + 1;
  localparam logic [CW-1:0] BIT_LD      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LD     = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0]   STATUS_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e        state_q, state_d;
  logic          rx_meta_q, rx_s_q, rx_d_q;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          stop_ok, stop_bad;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic          overrun_q, frame_err_q;
  logic          empty, full, pop, push, status_rd;

  // Synchronisers reset high so a released reset never looks like a start edge on an idle line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      rx_d_q    <= rx_s_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_d_q && !rx_s_q) begin
          bit_d   = '0;
          baud_d  = HALF_LD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_q == '0) begin
          baud_d  = BIT_LD;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      S_DATA: begin
        if (baud_q == '0) begin
          baud_d  = BIT_LD;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      S_STOP: begin
        if (baud_q == '0) begin
          stop_ok  = rx_s_q;
          stop_bad = !rx_s_q;
          state_d  = S_IDLE;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign empty     = (wr_q == rd_q);
  assign full      = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign status_rd = bus.read_enable && (bus.cpu_address == STATUS_ADDR);
  assign pop       = bus.read_enable && (bus.cpu_address == BASE_ADDR) && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign push      = stop_ok && (!full || pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (stop_ok && full && !pop) overrun_q <= 1'b1;
      else if (status_rd)          overrun_q <= 1'b0;
      if (stop_bad)       frame_err_q <= 1'b1;
      else if (status_rd) frame_err_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= shift_q;
  end

  always_comb begin
    bus.read_data = '0;
    if (bus.cpu_address == BASE_ADDR) begin
      if (!empty) bus.read_data = {24'b0, mem_q[rd_q[AW-1:0]]};
    end else if (bus.cpu_address == STATUS_ADDR) begin
      bus.read_data = {28'b0, frame_err_q, overrun_q, full, !empty};
    end
  end

  assign bus.rx_irq = !empty;

endmodule
